// File: rtl/pipe_barrel_shifter_if.sv
// Request/result bundle for pipe_barrel_shifter: valid/ready on both sides
// plus the operand, shift control and completed-transfer counter.
interface pipe_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dt;
  logic [SHW-1:0]   sv;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [15:0]      op_cnt;

  modport master (
    output in_valid, dt, sv, mode, out_ready,
    input  in_ready, out_valid, out, op_cnt
  );

  modport slave (
    input  in_valid, dt, sv, mode, out_ready,
    output in_ready, out_valid, out, op_cnt
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one log2 stage per register, stage k shifts by 2^k.
// Modes: 00 ROR, 01 ROL, 10 LSR, 11 ASR (sign captured at input).
module pipe_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  pipe_barrel_shifter_if.slave bus
);

  logic        advance;
  logic [15:0] cnt_reg;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_st
    localparam int S = 1 << gi;

    logic             src_vld;
    logic             src_sign;
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_sv;
    logic [1:0]       src_mode;
    logic [WIDTH-1:0] step;

    logic             vld_reg;
    logic             sign_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   sv_reg;
    logic [1:0]       mode_reg;

    if (gi == 0) begin : g_src
      assign src_vld  = bus.in_valid;
      assign src_sign = bus.dt[WIDTH-1];
      assign src_data = bus.dt;
      assign src_sv   = bus.sv;
      assign src_mode = bus.mode;
    end else begin : g_src
      assign src_vld  = g_st[gi-1].vld_reg;
      assign src_sign = g_st[gi-1].sign_reg;
      assign src_data = g_st[gi-1].data_reg;
      assign src_sv   = g_st[gi-1].sv_reg;
      assign src_mode = g_st[gi-1].mode_reg;
    end

    always_comb begin
      step = src_data;
      if (src_sv[gi]) begin
        case (src_mode)
          2'b00:   step = (src_data >> S) | (src_data << (WIDTH - S));
          2'b01:   step = (src_data << S) | (src_data >> (WIDTH - S));
          2'b10:   step = src_data >> S;
          default: step = (src_data >> S) | ({WIDTH{src_sign}} << (WIDTH - S));
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg  <= 1'b0;
        sign_reg <= 1'b0;
        data_reg <= '0;
        sv_reg   <= '0;
        mode_reg <= '0;
      end else if (advance) begin
        vld_reg  <= src_vld;
        sign_reg <= src_sign;
        data_reg <= step;
        sv_reg   <= src_sv;
        mode_reg <= src_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign bus.out_valid = g_st[SHW-1].vld_reg;
  assign bus.out       = g_st[SHW-1].data_reg;
  assign bus.op_cnt    = cnt_reg;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed-vector and streaming bench for pipe_barrel_shifter at WIDTH=32.
module tb_pipe_barrel_shifter;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sv;
    logic [31:0] dt;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_cnt;

  pipe_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

  pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] m);
    logic [63:0] t;
    logic [31:0] r;
    case (m)
      2'b00: begin t = {d, d} >> s; r = t[31:0]; end
      2'b01: begin t = {d, d} << s; r = t[63:32]; end
      2'b10: r = d >> s;
      default: r = $signed(d) >>> s;
    endcase
    return r;
  endfunction

  // Single op through an idle pipeline with out_ready=1; checks latency in edges.
  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dt        = v.dt;
    bus.sv        = v.sv;
    bus.mode      = v.mode;
    #1;
    check($sformatf("vec%0d_in_ready", idx), {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("vec%0d_latency", idx), n, SHW);
    check($sformatf("vec%0d_out", idx), bus.out, v.exp);
    @(posedge clk); #1;
    exp_cnt++;
    check($sformatf("vec%0d_op_cnt", idx), {16'd0, bus.op_cnt}, exp_cnt);
    $display("vec %0d mode=%0d sv=%0d dt=%h -> out=%h (exp %h)", idx, v.mode, v.sv, v.dt,
             bus.out, v.exp);
  endtask

  // Stream n random ops; out_ready held low for 'hold' cycles, then ready_pct% random.
  task automatic run_stream(input int n, input int ready_pct, input int hold, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] prev_out;
    logic [31:0] e;
    logic        prev_stall;
    logic        in_acc;
    logic        out_acc;
    logic        full_checked;
    int sent, got, cyc, limit;
    sent = 0; got = 0; cyc = 0; limit = n * 20 + 100;
    prev_stall = 1'b0; prev_out = '0; full_checked = 1'b0;
    bus.dt = $urandom; bus.sv = 5'($urandom_range(31)); bus.mode = 2'($urandom_range(3));
    while (got < n && cyc < limit) begin
      bus.out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      bus.in_valid  = (sent < n);
      #1;
      if (prev_stall) check($sformatf("%s_hold", tag), bus.out, prev_out);
      if (cyc < hold && sent == SHW && !full_checked) begin
        check($sformatf("%s_full_in_ready", tag), {31'd0, bus.in_ready}, 32'd0);
        full_checked = 1'b1;
      end
      in_acc  = bus.in_valid && bus.in_ready;
      out_acc = bus.out_valid && bus.out_ready;
      if (out_acc) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("%s_out%0d", tag, got), bus.out, e);
        $display("%s op %0d out=%h exp=%h", tag, got, bus.out, e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
      if (in_acc) exp_q.push_back(ref_shift(bus.dt, bus.sv, bus.mode));
      @(posedge clk); #1;
      if (in_acc) begin
        sent++;
        bus.dt = $urandom; bus.sv = 5'($urandom_range(31)); bus.mode = 2'($urandom_range(3));
      end
      if (out_acc) begin
        got++;
        exp_cnt++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s_all_received", tag), got, n);
    check($sformatf("%s_op_cnt", tag), {16'd0, bus.op_cnt}, exp_cnt);
  endtask

  vec_t vecs[13];

  initial begin
    checks = 0; errors = 0; exp_cnt = 0;
    vecs[0]  = '{2'b00, 5'd1,  32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{2'b01, 5'd4,  32'h8000_0001, 32'h0000_0018};
    vecs[2]  = '{2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{2'b10, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[4]  = '{2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 5'd4,  32'h4000_0000, 32'h0400_0000};
    vecs[6]  = '{2'b01, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[7]  = '{2'b11, 5'd0,  32'hF000_0000, 32'hF000_0000};
    vecs[8]  = '{2'b10, 5'd16, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[9]  = '{2'b00, 5'd8,  32'h0000_00FF, 32'hFF00_0000};
    vecs[10] = '{2'b01, 5'd31, 32'h8000_0000, 32'h4000_0000};
    vecs[11] = '{2'b11, 5'd5,  32'h8000_0000, 32'hFC00_0000};
    vecs[12] = '{2'b00, 5'd4,  32'h1234_5678, 32'h8123_4567};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dt = '0; bus.sv = '0; bus.mode = '0;
    #3;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_op_cnt", {16'd0, bus.op_cnt}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

    run_stream(8, 100, 8, "bp");
    run_stream(1000, 50, 0, "rnd");

    // Reset with three ops in flight: everything must vanish at once.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.dt = 32'hA5A5_0000 + i; bus.sv = 5'(i); bus.mode = 2'b10;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("flight_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flight_rst_op_cnt", {16'd0, bus.op_cnt}, 32'd0);
    check("flight_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_no_stale%0d", i), {31'd0, bus.out_valid}, 32'd0);
    end
    check("post_rst_op_cnt", {16'd0, bus.op_cnt}, 32'd0);
    apply_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
